dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU execute stage and a host/debug master (program loader, monitor), using a synchronous single-port RAM with 1-cycle read latency.
- The CPU has default priority. The host gets a guaranteed slot after a bounded wait.
- Produces cpu_stall, which drives the CPU wait_state. While stalled, the CPU freezes IP and both stacks and holds its request.

Parameters:
WIDTH, 16, data word width
DADDR_WIDTH, 8, data address width
HOST_MAX_WAIT, 4, cycles the host may be refused by the CPU before it is forced a slot; must be >=1 (elaboration error if 0)
CNT_WIDTH, 3, starvation counter width; must hold HOST_MAX_WAIT

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access this cycle (mem_read | mem_write)
cpu_write  in  1  CPU write
cpu_daddr  in  DADDR_WIDTH  CPU address
cpu_dD  in  WIDTH  CPU write data
cpu_dQ  out  WIDTH  CPU read data
cpu_stall  out  1  CPU request refused this cycle
h_valid  in  1  host request
h_write  in  1  host write
h_addr  in  DADDR_WIDTH  host address
h_wdata  in  WIDTH  host write data
h_ready  out  1  host request accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  WIDTH  host read data
m_addr  out  DADDR_WIDTH  RAM address
m_we  out  1  RAM write enable
m_wdata  out  WIDTH  RAM write data
m_rdata  in  WIDTH  RAM read data, valid the cycle after the address
owner  out  2  registered owner of the previous cycle: 0 none, 1 CPU, 2 host

Behaviour:
- Arbitration is combinational within the cycle:
  - host_win = h_valid & (~cpu_req | starve_cnt == HOST_MAX_WAIT)
  - h_ready = host_win
  - cpu_stall = cpu_req & host_win
  - cpu_grant = cpu_req & ~host_win
- RAM port mux:
  - host_win: m_addr=h_addr, m_we=h_write, m_wdata=h_wdata.
  - cpu_grant: the cpu_* equivalents.
  - Neither: m_addr=cpu_daddr, m_we=0, m_wdata=cpu_dD.
  - m_we is never 1 unless a grant exists.
- starve_cnt (CNT_WIDTH bits):
  - Reset to 0.
  - Cleared when host_win or ~h_valid.
  - Otherwise (h_valid & cpu_req & ~host_win) incremented, saturating at HOST_MAX_WAIT.
- Consequence: a host forced through costs the CPU exactly one stall cycle. The counter is 0 in the next cycle, so the CPU cannot be stalled twice in any HOST_MAX_WAIT+1 window.
- Host read pipeline:
  - rd_pend register is set to host_win & ~h_write each cycle and cleared by reset.
  - h_rvalid = rd_pend; h_rdata = m_rdata.
  - Latency: accept at cycle N gives data at N+1.
  - Back-to-back host reads are allowed every cycle.
  - Host writes produce no h_rvalid.
- cpu_dQ = m_rdata, valid the cycle after a CPU read grant. The CPU samples it only when not stalled.
- owner register:
  - Reset to 0.
  - Each cycle loads 2 if host_win, 1 if cpu_grant, else 0.
- Simultaneous same-address CPU write and host read: impossible, only one grant per cycle.
- Host requests are not buffered. Host must hold h_valid and its payload stable until h_ready.
- Reset mid-read: rd_pend cleared, so no h_rvalid for the aborted read; starve_cnt=0; owner=0.
- Output reset values: cpu_stall, h_ready and m_we follow their equations from the inputs (0 when no request is present). h_rvalid=0, owner=0.

Optional Feature:
- Macro DMEM_ARBITER_FAIR_EN.
- When defined: starvation counter and forced host slot exist as above.
- When undefined: strict CPU priority.
  - host_win = h_valid & ~cpu_req.
  - cpu_stall is constant 0.
  - starve_cnt is not instantiated.
  - The host may starve indefinitely.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - owner encoding constants OWN_NONE=0, OWN_CPU=1, OWN_HOST=2
  - the elaboration check helper for HOST_MAX_WAIT/CNT_WIDTH
- One sub-module, starve_counter: saturating counter with clear/inc/limit compare. It is instantiated only under DMEM_ARBITER_FAIR_EN.

Test Plan:
- Host only: write 0x1234 to 0x10, then read 0x10. Required: h_ready=1 on both accepts, m_we=1 only on the write, h_rvalid=1 with h_rdata=0x1234 the cycle after the read accept.
- CPU only: cpu_req continuous for 10 cycles, h_valid=0. Required: cpu_stall=0 throughout, owner=1 from cycle 2 on.
- Contention, FAIR_EN, HOST_MAX_WAIT=4: cpu_req and h_valid held high. Required: h_ready=0 for 4 cycles, h_ready=cpu_stall=1 on the 5th, then the pattern repeats every 5 cycles.
- Contention, FAIR_EN undefined: same stimulus for 20 cycles. Required: h_ready=0 and cpu_stall=0 throughout.
- Host read at address 0x20 (holding 0xBEEF) accepted at cycle N, reset asserted at cycle N+1. Required: h_rvalid=0 at N+1, owner=0, starve_cnt=0 after reset.
- Back-to-back host reads of 0x01, 0x02, 0x03 with the CPU idle. Required: h_rvalid high for 3 consecutive cycles returning each address's contents in order.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: owner encoding and the
// configuration check for the host starvation limit.
package dmem_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  // The limit must be at least one refusal and must fit in the counter.
  function automatic bit starve_cfg_ok(input int host_max_wait, input int cnt_width);
    return (host_max_wait >= 1) && (cnt_width >= 1) && (cnt_width < 31) &&
           (host_max_wait < (1 << cnt_width));
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating refusal counter: clear wins over increment, and o_at_limit
// flags that the host has waited long enough to be forced a slot.
module starve_counter #(
  parameter int CNT_WIDTH = 3,
  parameter int LIMIT     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(LIMIT);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port data RAM between the CPU and a host.
// Define DMEM_ARBITER_FAIR_EN to bound host starvation; otherwise CPU priority is strict.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DADDR_WIDTH   = 8,
  parameter int HOST_MAX_WAIT = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_write,
  input  logic [DADDR_WIDTH-1:0] cpu_daddr,
  input  logic [WIDTH-1:0]       cpu_dD,
  output logic [WIDTH-1:0]       cpu_dQ,
  output logic                   cpu_stall,
  input  logic                   h_valid,
  input  logic                   h_write,
  input  logic [DADDR_WIDTH-1:0] h_addr,
  input  logic [WIDTH-1:0]       h_wdata,
  output logic                   h_ready,
  output logic                   h_rvalid,
  output logic [WIDTH-1:0]       h_rdata,
  output logic [DADDR_WIDTH-1:0] m_addr,
  output logic                   m_we,
  output logic [WIDTH-1:0]       m_wdata,
  input  logic [WIDTH-1:0]       m_rdata,
  output logic [1:0]             owner
);

  if (!starve_cfg_ok(HOST_MAX_WAIT, CNT_WIDTH)) begin : g_bad_cfg
    $error("dmem_arbiter: HOST_MAX_WAIT must be >= 1 and fit in CNT_WIDTH bits");
  end

  logic       w_host_win;
  logic       w_cpu_grant;
  logic       r_rd_pend;
  logic [1:0] r_owner;

  // Host handshake: a transfer happens in any cycle where h_valid and h_ready
  // are both high; the host holds h_valid and its payload stable until then.
  // h_ready is combinational from this cycle's requests.
`ifdef DMEM_ARBITER_FAIR_EN
  logic w_force_host;

  starve_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .LIMIT     (HOST_MAX_WAIT)
  ) u_starve_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_host_win | ~h_valid),
    .i_inc      (h_valid & cpu_req & ~w_host_win),
    .o_at_limit (w_force_host)
  );

  assign w_host_win = h_valid & (~cpu_req | w_force_host);
  assign cpu_stall  = cpu_req & w_host_win;
`else
  assign w_host_win = h_valid & ~cpu_req;
  assign cpu_stall  = 1'b0;
`endif

  assign w_cpu_grant = cpu_req & ~w_host_win;
  assign h_ready     = w_host_win;

  // With no grant the CPU address still drives the RAM so reads stay cheap to
  // decode, but the write enable is held off.
  always_comb begin
    m_addr  = cpu_daddr;
    m_wdata = cpu_dD;
    m_we    = 1'b0;
    if (w_host_win) begin
      m_addr  = h_addr;
      m_wdata = h_wdata;
      m_we    = h_write;
    end else if (w_cpu_grant) begin
      m_we    = cpu_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_owner   <= OWN_NONE;
    end else begin
      r_rd_pend <= w_host_win & ~h_write;
      if (w_host_win) begin
        r_owner <= OWN_HOST;
      end else if (w_cpu_grant) begin
        r_owner <= OWN_CPU;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign h_rvalid = r_rd_pend;
  assign h_rdata  = m_rdata;
  assign cpu_dQ   = m_rdata;
  assign owner    = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, compared against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int WIDTH = 16;
  localparam int DADDR_WIDTH = 8;
  localparam int HOST_MAX_WAIT = 4;
  localparam int CNT_WIDTH = 3;
`ifdef DMEM_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                   cpu_req = 1'b0, cpu_write = 1'b0;
  logic [DADDR_WIDTH-1:0] cpu_daddr = '0;
  logic [WIDTH-1:0]       cpu_dD = '0;
  logic [WIDTH-1:0]       cpu_dQ;
  logic                   cpu_stall;
  logic                   h_valid = 1'b0, h_write = 1'b0;
  logic [DADDR_WIDTH-1:0] h_addr = '0;
  logic [WIDTH-1:0]       h_wdata = '0;
  logic                   h_ready, h_rvalid;
  logic [WIDTH-1:0]       h_rdata;
  logic [DADDR_WIDTH-1:0] m_addr;
  logic                   m_we;
  logic [WIDTH-1:0]       m_wdata;
  logic [WIDTH-1:0]       m_rdata;
  logic [1:0]             owner;

  dmem_arbiter #(
    .WIDTH(WIDTH), .DADDR_WIDTH(DADDR_WIDTH),
    .HOST_MAX_WAIT(HOST_MAX_WAIT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_daddr(cpu_daddr),
    .cpu_dD(cpu_dD), .cpu_dQ(cpu_dQ), .cpu_stall(cpu_stall),
    .h_valid(h_valid), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ready(h_ready), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .owner(owner)
  );

  // Environment RAM: synchronous, 1-cycle read latency, read-before-write.
  logic [WIDTH-1:0] ram [256];
  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_wdata;
    m_rdata <= ram[m_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] ref_mem [256];
  logic [WIDTH-1:0] exp_q [$];
  int               refusals = 0;
  logic [1:0]       exp_owner = 2'd0;
  bit               exp_rd_pend = 1'b0;
  bit               exp_cpu_rd = 1'b0;
  logic [WIDTH-1:0] exp_cpu_dq = '0;
  bit               last_host_acc = 1'b0;
  bit               last_cpu_stall = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cpu(input bit req, input bit wr, input int addr, input int data);
    cpu_req = req; cpu_write = wr;
    cpu_daddr = DADDR_WIDTH'(addr); cpu_dD = WIDTH'(data);
  endtask

  task automatic set_host(input bit v, input bit wr, input int addr, input int data);
    h_valid = v; h_write = wr;
    h_addr = DADDR_WIDTH'(addr); h_wdata = WIDTH'(data);
  endtask

  // Called #1 after a rising edge with inputs applied; checks mid-cycle and
  // advances the model across the next rising edge.
  task automatic do_cycle();
    bit hw, cg;
    logic [WIDTH-1:0] rd;
    hw = h_valid && (!cpu_req || (FAIR && refusals == HOST_MAX_WAIT));
    cg = cpu_req && !hw;
    #3;
    check_val("h_ready", 32'(h_ready), 32'(hw));
    check_val("cpu_stall", 32'(cpu_stall), 32'(cpu_req && hw));
    check_val("m_we", 32'(m_we), hw ? 32'(h_write) : (cg ? 32'(cpu_write) : 32'd0));
    check_val("m_addr", 32'(m_addr), hw ? 32'(h_addr) : 32'(cpu_daddr));
    check_val("m_wdata", 32'(m_wdata), hw ? 32'(h_wdata) : 32'(cpu_dD));
    check_val("owner", 32'(owner), 32'(exp_owner));
    check_val("h_rvalid", 32'(h_rvalid), 32'(exp_rd_pend));
    if (exp_rd_pend && exp_q.size() > 0) begin
      rd = exp_q.pop_front();
      check_val("h_rdata", 32'(h_rdata), 32'(rd));
    end
    if (exp_cpu_rd) check_val("cpu_dQ", 32'(cpu_dQ), 32'(exp_cpu_dq));
    exp_cpu_rd = cg && !cpu_write;
    if (exp_cpu_rd) exp_cpu_dq = ref_mem[cpu_daddr];
    exp_rd_pend = hw && !h_write;
    if (exp_rd_pend) exp_q.push_back(ref_mem[h_addr]);
    if (hw && h_write) ref_mem[h_addr] = h_wdata;
    else if (cg && cpu_write) ref_mem[cpu_daddr] = cpu_dD;
    exp_owner = hw ? 2'd2 : (cg ? 2'd1 : 2'd0);
    if (hw || !h_valid) refusals = 0;
    else if (refusals < HOST_MAX_WAIT) refusals++;
    last_host_acc = hw;
    last_cpu_stall = cpu_req && hw;
    @(posedge clk); #1;
  endtask

  // Asynchronous reset for one cycle with the current inputs held.
  task automatic do_reset();
    bit hw, cg;
    reset = 1'b1;
    exp_q.delete();
    exp_rd_pend = 1'b0; exp_cpu_rd = 1'b0; exp_owner = 2'd0; refusals = 0;
    hw = h_valid && (!cpu_req || (FAIR && refusals == HOST_MAX_WAIT));
    cg = cpu_req && !hw;
    #3;
    check_val("rst_h_rvalid", 32'(h_rvalid), 32'd0);
    check_val("rst_owner", 32'(owner), 32'd0);
    check_val("rst_h_ready", 32'(h_ready), 32'(hw));
    check_val("rst_cpu_stall", 32'(cpu_stall), 32'(cpu_req && hw));
    if (hw && h_write) ref_mem[h_addr] = h_wdata;
    else if (cg && cpu_write) ref_mem[cpu_daddr] = cpu_dD;
    last_host_acc = hw;
    last_cpu_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle_all();
    set_cpu(0, 0, 0, 0);
    set_host(0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    #2;
    check_val("init_owner", 32'(owner), 32'd0);
    check_val("init_h_rvalid", 32'(h_rvalid), 32'd0);
    check_val("init_cpu_stall", 32'(cpu_stall), 32'd0);
    check_val("init_h_ready", 32'(h_ready), 32'd0);
    check_val("init_m_we", 32'(m_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Host only: write then read back.
    set_host(1, 1, 'h10, 'h1234); do_cycle();
    set_host(1, 0, 'h10, 0);      do_cycle();
    idle_all();                   do_cycle();

    // CPU only for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      set_cpu(1, i[0], 'h40 + (i % 3), $urandom_range(0, 16'hFFFF));
      do_cycle();
    end
    idle_all(); do_cycle();

    // Sustained contention: forced slot pattern (fair) or total starvation.
    for (int i = 0; i < 20; i++) begin
      set_cpu(1, 0, 'h05, 0);
      set_host(1, 0, 'h06, 0);
      do_cycle();
    end
    idle_all(); do_cycle();

    // Reset mid-contention, then contention again from a clean counter.
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 0, 'h07, 0); set_host(1, 0, 'h08, 0); do_cycle();
    end
    do_reset();
    for (int i = 0; i < 6; i++) do_cycle();
    idle_all(); do_cycle();

    // Host read of 0x20 holding 0xBEEF, reset the cycle after accept.
    set_host(1, 1, 'h20, 'hBEEF); do_cycle();
    set_host(1, 0, 'h20, 0);      do_cycle();
    idle_all();                   do_reset();
    do_cycle();

    // Back-to-back host reads of 0x01..0x03.
    for (int a = 1; a <= 3; a++) begin
      set_host(1, 1, a, 'hA000 + a * 'h111); do_cycle();
    end
    for (int a = 1; a <= 3; a++) begin
      set_host(1, 0, a, 0); do_cycle();
    end
    idle_all(); do_cycle();

    // Randomized traffic; host holds its request until accepted, CPU holds while stalled.
    for (int i = 0; i < 400; i++) begin
      if (!last_cpu_stall)
        set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1),
                $urandom_range(0, 15), $urandom_range(0, 16'hFFFF));
      if (!h_valid || last_host_acc)
        set_host($urandom_range(0, 99) < 50, $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 16'hFFFF));
      do_cycle();
    end
    idle_all(); do_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
